// File: rtl/fp_int2fp_pipe_pkg.sv
// Shared FPU conversion definitions: rounding-mode encoding, format constant helpers
// and the per-stage control record used by the int-to-float pipeline.
package fp_int2fp_pipe_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RDN = 2'b10,
    RND_RUP = 2'b11
  } fp_rnd_mode_t;

  // Widest encoding the helpers can describe; callers slice down to their format.
  localparam int FP_MAX_WIDTH = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Magnitude bits (sign excluded) of +Inf: all-ones exponent, zero fraction.
  function automatic logic [FP_MAX_WIDTH-1:0] fp_inf_mag(input int exp_w, input int mant_w);
    logic [FP_MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[mant_w+i] = 1'b1;
    return r;
  endfunction

  // Magnitude bits of the largest finite value: exponent all-ones minus one, fraction all ones.
  function automatic logic [FP_MAX_WIDTH-1:0] fp_max_mag(input int exp_w, input int mant_w);
    logic [FP_MAX_WIDTH-1:0] r;
    r = fp_inf_mag(exp_w, mant_w);
    r[mant_w] = 1'b0;
    for (int i = 0; i < mant_w; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Width-independent part of a pipeline slot; id, exponent and mantissa sit beside it
  // because their widths follow the instance parameters.
  typedef struct packed {
    logic         valid;
    logic         sign;
    logic         zero;
    fp_rnd_mode_t rnd;
  } fp_stage_ctl_t;

endpackage

// File: rtl/fp_int2fp_pipe_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  logic found;

  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_int2fp_pipe.sv
// Three-stage integer to IEEE-754 converter (capture, normalise, round/pack) with global stall.
// Optional macro FP_INT2FP_ROUND_MODE_EN adds a per-operation rnd_mode port; otherwise RNE only.
module fp_int2fp_pipe
  import fp_int2fp_pipe_pkg::*;
#(
  parameter  int INT_WIDTH  = 64,
  parameter  int EXP_WIDTH  = 11,
  parameter  int MANT_WIDTH = 52,
  parameter  int ID_WIDTH   = 6,
  localparam int FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic                 in_signed,
  input  logic [ID_WIDTH-1:0]  in_id,
  input  logic [INT_WIDTH-1:0] op0,
`ifdef FP_INT2FP_ROUND_MODE_EN
  input  logic [1:0]           rnd_mode,
`endif
  output logic                 out_valid,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic [FP_WIDTH-1:0]  res,
  output logic                 out_inexact,
  output logic                 out_overflow
);

  // Handshake: in_valid qualifies the operand only when stall is low; there is no ready.
  // out_valid marks a result for one enabled cycle and holds with everything else under stall.

  localparam int LZW = $clog2(INT_WIDTH) + 1;
  localparam int XW  = ((LZW > EXP_WIDTH) ? LZW : EXP_WIDTH) + 2;

  localparam logic [FP_MAX_WIDTH-1:0] INF_MAG = fp_inf_mag(EXP_WIDTH, MANT_WIDTH);
  localparam logic [FP_MAX_WIDTH-1:0] MAX_MAG = fp_max_mag(EXP_WIDTH, MANT_WIDTH);
  localparam logic [FP_WIDTH-2:0]     INF_BITS = INF_MAG[FP_WIDTH-2:0];
  localparam logic [FP_WIDTH-2:0]     MAX_BITS = MAX_MAG[FP_WIDTH-2:0];
  localparam logic [XW-1:0]           BIAS     = XW'(fp_bias(EXP_WIDTH));
  localparam logic [XW-1:0]           EXP_MAX  = XW'((1 << EXP_WIDTH) - 1);

  // ---------------- S1: capture sign and magnitude ----------------
  logic                 s1_valid;
  logic                 s1_sign;
  fp_rnd_mode_t         s1_rnd;
  logic [ID_WIDTH-1:0]  s1_id;
  logic [INT_WIDTH-1:0] s1_mag;

  logic                 op_neg;
  logic [INT_WIDTH-1:0] mag_d;
  fp_rnd_mode_t         rnd_d;

  always_comb begin
    op_neg = in_signed & op0[INT_WIDTH-1];
    // Negating the most negative value wraps to 2^(INT_WIDTH-1), the correct unsigned magnitude.
    mag_d  = op_neg ? (~op0 + INT_WIDTH'(1)) : op0;
`ifdef FP_INT2FP_ROUND_MODE_EN
    rnd_d  = fp_rnd_mode_t'(rnd_mode);
`else
    rnd_d  = RND_RNE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rnd   <= RND_RNE;
      s1_id    <= '0;
      s1_mag   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_sign  <= op_neg;
      s1_rnd   <= rnd_d;
      s1_id    <= in_id;
      s1_mag   <= mag_d;
    end
  end

  // ---------------- S2: normalise ----------------
  fp_stage_ctl_t        s2_ctl;
  logic [ID_WIDTH-1:0]  s2_id;
  logic [XW-1:0]        s2_exp;
  logic [INT_WIDTH-2:0] s2_tail;

  logic [LZW-1:0]       lz;
  logic [INT_WIDTH-1:0] norm_d;
  logic [XW-1:0]        exp_d;

  fp_lzc #(.WIDTH(INT_WIDTH)) u_lzc (
    .data  (s1_mag),
    .count (lz)
  );

  always_comb begin
    norm_d = s1_mag << lz;
    exp_d  = XW'(INT_WIDTH - 1) - XW'(lz);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_ctl  <= '0;
      s2_id   <= '0;
      s2_exp  <= '0;
      s2_tail <= '0;
    end else if (!stall) begin
      s2_ctl.valid <= s1_valid;
      s2_ctl.sign  <= s1_sign;
      // After normalisation the top bit is clear only for a zero magnitude.
      s2_ctl.zero  <= ~norm_d[INT_WIDTH-1];
      s2_ctl.rnd   <= s1_rnd;
      s2_id        <= s1_id;
      s2_exp       <= exp_d;
      s2_tail      <= norm_d[INT_WIDTH-2:0];
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [MANT_WIDTH-1:0] frac;
  logic                  guard;
  logic                  sticky;

  if (INT_WIDTH - 1 > MANT_WIDTH) begin : g_round
    localparam int GB = INT_WIDTH - 2 - MANT_WIDTH;
    assign frac  = s2_tail[INT_WIDTH-2 -: MANT_WIDTH];
    assign guard = s2_tail[GB];
    if (GB > 0) begin : g_sticky
      assign sticky = |s2_tail[GB-1:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  end else begin : g_exact
    // Every integer fits the fraction, so nothing is ever dropped.
    assign frac   = MANT_WIDTH'(s2_tail) << (MANT_WIDTH - (INT_WIDTH - 1));
    assign guard  = 1'b0;
    assign sticky = 1'b0;
  end

  logic                  round_up;
  logic                  sat_max;
  logic [MANT_WIDTH:0]   mant_rnd;
  logic [XW-1:0]         biased;
  logic                  ovf;
  logic [FP_WIDTH-1:0]   res_d;
  logic                  inexact_d;

  always_comb begin
    round_up = 1'b0;
    sat_max  = 1'b0;
    case (s2_ctl.rnd)
      RND_RNE: round_up = guard & (sticky | frac[0]);
      RND_RTZ: begin
        round_up = 1'b0;
        sat_max  = 1'b1;
      end
      RND_RDN: begin
        round_up = s2_ctl.sign & (guard | sticky);
        sat_max  = ~s2_ctl.sign;
      end
      RND_RUP: begin
        round_up = ~s2_ctl.sign & (guard | sticky);
        sat_max  = s2_ctl.sign;
      end
    endcase

    // A carry out of the fraction leaves it zero and bumps the exponent.
    mant_rnd  = {1'b0, frac} + (MANT_WIDTH+1)'(round_up);
    biased    = s2_exp + XW'(mant_rnd[MANT_WIDTH]) + BIAS;
    ovf       = ~s2_ctl.zero & (biased >= EXP_MAX);
    inexact_d = ~s2_ctl.zero & (guard | sticky | ovf);

    if (s2_ctl.zero)
      res_d = '0;
    else if (ovf)
      res_d = {s2_ctl.sign, sat_max ? MAX_BITS : INF_BITS};
    else
      res_d = {s2_ctl.sign, biased[EXP_WIDTH-1:0], mant_rnd[MANT_WIDTH-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_id       <= '0;
      res          <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (!stall) begin
      out_valid    <= s2_ctl.valid;
      out_id       <= s2_id;
      res          <= res_d;
      out_inexact  <= inexact_d;
      out_overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_fp_int2fp_pipe.sv
// Directed bench for fp_int2fp_pipe: a double-format instance (64-bit int) and a half-format
// instance (32-bit int) share clock, reset and stall.
module tb_fp_int2fp_pipe;

  logic clk;
  logic rst;
  logic stall;

  logic        d_in_valid, d_in_signed;
  logic [5:0]  d_in_id;
  logic [63:0] d_op0;
  logic        d_out_valid, d_inexact, d_overflow;
  logic [5:0]  d_out_id;
  logic [63:0] d_res;

  logic        h_in_valid, h_in_signed;
  logic [5:0]  h_in_id;
  logic [31:0] h_op0;
  logic        h_out_valid, h_inexact, h_overflow;
  logic [5:0]  h_out_id;
  logic [15:0] h_res;

`ifdef FP_INT2FP_ROUND_MODE_EN
  logic [1:0] d_rnd, h_rnd;
`endif

  fp_int2fp_pipe dut (
    .clk (clk), .rst (rst), .stall (stall),
    .in_valid (d_in_valid), .in_signed (d_in_signed), .in_id (d_in_id), .op0 (d_op0),
`ifdef FP_INT2FP_ROUND_MODE_EN
    .rnd_mode (d_rnd),
`endif
    .out_valid (d_out_valid), .out_id (d_out_id), .res (d_res),
    .out_inexact (d_inexact), .out_overflow (d_overflow)
  );

  fp_int2fp_pipe #(.INT_WIDTH(32), .EXP_WIDTH(5), .MANT_WIDTH(10), .ID_WIDTH(6)) dut_h (
    .clk (clk), .rst (rst), .stall (stall),
    .in_valid (h_in_valid), .in_signed (h_in_signed), .in_id (h_in_id), .op0 (h_op0),
`ifdef FP_INT2FP_ROUND_MODE_EN
    .rnd_mode (h_rnd),
`endif
    .out_valid (h_out_valid), .out_id (h_out_id), .res (h_res),
    .out_inexact (h_inexact), .out_overflow (h_overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        half;
    logic        sgn;
    logic [63:0] op;
    logic [63:0] res;
    logic        inx;
    logic        ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  logic [69:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input logic [5:0] id, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (!v.half) begin
      d_in_valid = 1'b1; d_in_signed = v.sgn; d_in_id = id; d_op0 = v.op;
    end else begin
      h_in_valid = 1'b1; h_in_signed = v.sgn; h_in_id = id; h_op0 = v.op[31:0];
    end
    step();
    d_in_valid = 1'b0;
    h_in_valid = 1'b0;
    step();
    check({tag, "_early"}, {63'b0, v.half ? h_out_valid : d_out_valid}, 64'd0);
    step();
    if (!v.half) begin
      check({tag, "_valid"}, {63'b0, d_out_valid}, 64'd1);
      check({tag, "_id"},    {58'b0, d_out_id}, {58'b0, id});
      check({tag, "_res"},   d_res, v.res);
      check({tag, "_inx"},   {63'b0, d_inexact}, {63'b0, v.inx});
      check({tag, "_ovf"},   {63'b0, d_overflow}, {63'b0, v.ovf});
    end else begin
      check({tag, "_valid"}, {63'b0, h_out_valid}, 64'd1);
      check({tag, "_id"},    {58'b0, h_out_id}, {58'b0, id});
      check({tag, "_res"},   {48'b0, h_res}, v.res);
      check({tag, "_inx"},   {63'b0, h_inexact}, {63'b0, v.inx});
      check({tag, "_ovf"},   {63'b0, h_overflow}, {63'b0, v.ovf});
    end
  endtask

  initial begin
    // half, signed, op0, expected res, inexact, overflow
    vecs[0]  = '{1'b0, 1'b0, 64'd1,                  64'h3FF0000000000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF,   64'hBFF0000000000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 64'h8000000000000000,   64'hC3E0000000000000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 64'h0020000000000001,   64'h4340000000000000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF,   64'h43F0000000000000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 64'd0,                  64'h0,                1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'd0,                  64'h0,                1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 64'd3,                  64'h4008000000000000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE,   64'hC000000000000000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 64'h0020000000000003,   64'h4340000000000002, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 64'h8000000000000000,   64'h43E0000000000000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF,   64'h43E0000000000000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 64'd5,                  64'h4014000000000000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 64'd70000,              64'h7C00,             1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 64'd65535,              64'h7C00,             1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 64'd65504,              64'h7BFF,             1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 64'd2049,               64'h6800,             1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 64'd2051,               64'h6802,             1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 64'hFFFFFFFF,           64'hBC00,             1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 64'hFFFFFFFF,           64'h7C00,             1'b1, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 64'h80000000,           64'hFC00,             1'b1, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 64'd0,                  64'h0,                1'b0, 1'b0};

    rst = 1'b1; stall = 1'b0;
    d_in_signed = 1'b0; d_in_id = 6'd0; d_op0 = '0;
    h_in_signed = 1'b0; h_in_id = 6'd0; h_op0 = '0;
`ifdef FP_INT2FP_ROUND_MODE_EN
    d_rnd = 2'b00; h_rnd = 2'b00;
`endif
    // Operands presented during reset must never be captured.
    d_in_valid = 1'b1; d_op0 = 64'd9; d_in_id = 6'd63;
    h_in_valid = 1'b1; h_op0 = 32'd9; h_in_id = 6'd63;
    step(); step();
    check("rst_out_valid", {63'b0, d_out_valid}, 64'd0);
    check("rst_res", d_res, 64'd0);
    check("rst_id", {58'b0, d_out_id}, 64'd0);
    check("rst_flags", {62'b0, d_inexact, d_overflow}, 64'd0);
    check("rst_h_valid", {63'b0, h_out_valid}, 64'd0);
    d_in_valid = 1'b0; h_in_valid = 1'b0;
    rst = 1'b0;
    step(); step(); step();
    check("rst_no_capture", {62'b0, d_out_valid, h_out_valid}, 64'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 6'(i + 1), i);

`ifdef FP_INT2FP_ROUND_MODE_EN
    h_rnd = 2'b01;
    run_vec('{1'b1, 1'b0, 64'd70000, 64'h7BFF, 1'b1, 1'b1}, 6'd50, 100);
    h_rnd = 2'b11;
    run_vec('{1'b1, 1'b1, 64'hFFFEEE90, 64'hFBFF, 1'b1, 1'b1}, 6'd51, 101);
    h_rnd = 2'b00;
`endif

    // ---------------- streaming with a mid-stream stall ----------------
    begin
      int sent;
      int got;
      logic        stalled_edge;
      logic        pv;
      logic [5:0]  pid;
      logic [63:0] pres;
      logic [69:0] e;
      sent = 0; got = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
        stall = (cyc == 5 || cyc == 6);
        if (!stall && sent < 8) begin
          sent++;
          d_in_valid = 1'b1; d_in_signed = 1'b0;
          d_in_id = 6'(sent); d_op0 = 64'(sent * 12345);
          exp_q.push_back({6'(sent), $realtobits(real'(sent * 12345))});
        end else begin
          d_in_valid = 1'b0;
        end
        stalled_edge = stall;
        pv = d_out_valid; pid = d_out_id; pres = d_res;
        step();
        if (stalled_edge) begin
          check("stall_hold_valid", {63'b0, d_out_valid}, {63'b0, pv});
          check("stall_hold_id", {58'b0, d_out_id}, {58'b0, pid});
          check("stall_hold_res", d_res, pres);
        end else if (d_out_valid) begin
          got++;
          if (exp_q.size() == 0) begin
            check("stream_extra", {58'b0, d_out_id}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("stream_id", {58'b0, d_out_id}, {58'b0, e[69:64]});
            check("stream_res", d_res, e[63:0]);
          end
        end
      end
      stall = 1'b0;
      d_in_valid = 1'b0;
      check("stream_count", 64'(got), 64'd8);
      check("stream_left", 64'(exp_q.size()), 64'd0);
    end

    // ---------------- reset with three operations in flight ----------------
    begin
      int ghosts;
      ghosts = 0;
      d_in_signed = 1'b0;
      d_in_valid = 1'b1; d_in_id = 6'd40; d_op0 = 64'd5; step();
      d_in_id = 6'd41; d_op0 = 64'd6; step();
      d_in_id = 6'd42; d_op0 = 64'd7; step();
      d_in_valid = 1'b0;
      check("flight_valid", {63'b0, d_out_valid}, 64'd1);
      check("flight_id", {58'b0, d_out_id}, 64'd40);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", {63'b0, d_out_valid}, 64'd0);
      check("async_rst_res", d_res, 64'd0);
      check("async_rst_id", {58'b0, d_out_id}, 64'd0);
      check("async_rst_flags", {62'b0, d_inexact, d_overflow}, 64'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (d_out_valid) ghosts++;
      end
      check("no_ghost", 64'(ghosts), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
